// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and branch handling,
// a bounded memory-wait freeze with a sticky timeout flag, and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int TIMEOUT     = 15,
    parameter int INIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [1:0]  ResultSrcE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MemErr,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int IW = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES);
    localparam logic [WW-1:0] TIMEOUT_W = WW'(TIMEOUT);
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_MEM_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   init_cnt_q, init_cnt_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            mem_err_q, mem_err_d;
    logic [15:0]     stall_cnt_q, flush_cnt_q;
    logic            lw_stall, mem_pending, mem_stall;

    // Memory stage has priority over Writeback because it holds the younger result.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)
            ForwardAE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E)
            ForwardAE = 2'b01;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)
            ForwardBE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E)
            ForwardBE = 2'b01;
    end

    assign lw_stall    = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_pending = MemReqM && !MemReadyM;
    assign mem_stall   = mem_pending && (wait_cnt_q < TIMEOUT_W) && (state_q != ST_INIT);

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushW     = 1'b0;
        case (state_q)
            ST_INIT: begin
                StallF = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
                FlushW = 1'b1;
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                    wait_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + IW'(1);
                end
            end
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_stall) begin
                    StallF     = 1'b1;
                    StallD     = 1'b1;
                    StallE     = 1'b1;
                    StallM     = 1'b1;
                    FlushW     = 1'b1;
                    wait_cnt_d = wait_cnt_q + WW'(1);
                    state_d    = ST_MEM_WAIT;
                end else begin
                    // Still pending here means the wait budget ran out: release and flag it.
                    if (state_q == ST_MEM_WAIT && mem_pending)
                        mem_err_d = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_RUN;
                    if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (lw_stall) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            if (StallF && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (FlushE && flush_cnt_q != 16'hFFFF)
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign MemErr     = mem_err_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for forwarding and load-use/branch
// decisions, plus hand-written sequences for init, memory wait, timeout, saturation and reset.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  ResultSrcE;
    logic        RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MemErr;
    logic [15:0] StallCount, FlushCount;

    int total = 0;
    int bad   = 0;
    int exp_sc = 0;
    int exp_fc = 0;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LW   = 7'b1100010;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_MEM  = 7'b1111001;
    localparam logic [6:0] C_INIT = 7'b1000111;

    logic [6:0] ctl;
    assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    hazard_ctrl #(.TIMEOUT(15), .INIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic [1:0] rsrc;
        logic [4:0] rdm, rdw;
        logic       rwm, rww, pc;
        logic [6:0] ctl;
        logic [1:0] fa, fb;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde,
                                input logic [1:0] rsrc, input logic [4:0] rdm, rdw,
                                input logic rwm, rww, pc,
                                input logic [6:0] c, input logic [1:0] fa, fb);
        vec_t v;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e; v.rde = rde;
        v.rsrc = rsrc; v.rdm = rdm; v.rdw = rdw; v.rwm = rwm; v.rww = rww; v.pc = pc;
        v.ctl = c; v.fa = fa; v.fb = fb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Advances one clock; the bench's own counter model follows the expected StallF/FlushE.
    task automatic tick(input logic sf, input logic fe);
        if (sf && exp_sc < 16'hFFFF) exp_sc++;
        if (fe && exp_fc < 16'hFFFF) exp_fc++;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 2'b00; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_stallcount"}, 32'(StallCount), 32'(exp_sc));
        chk({tag, "_flushcount"}, 32'(FlushCount), 32'(exp_fc));
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = mk(0, 0, 5, 0, 0, 2'b00, 5, 5, 1, 1, 0, C_NONE, 2'b10, 2'b00);
        vecs[1]  = mk(0, 0, 5, 0, 0, 2'b00, 0, 5, 1, 1, 0, C_NONE, 2'b01, 2'b00);
        vecs[2]  = mk(0, 0, 5, 0, 0, 2'b00, 0, 0, 1, 1, 0, C_NONE, 2'b00, 2'b00);
        vecs[3]  = mk(0, 0, 0, 7, 0, 2'b00, 7, 7, 0, 1, 0, C_NONE, 2'b00, 2'b01);
        vecs[4]  = mk(0, 0, 9, 9, 0, 2'b00, 9, 0, 1, 0, 0, C_NONE, 2'b10, 2'b10);
        vecs[5]  = mk(0, 3, 0, 0, 3, 2'b01, 0, 0, 0, 0, 0, C_LW,   2'b00, 2'b00);
        vecs[6]  = mk(0, 3, 0, 0, 3, 2'b01, 0, 0, 0, 0, 1, C_BR,   2'b00, 2'b00);
        vecs[7]  = mk(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00);
        vecs[8]  = mk(3, 0, 0, 0, 3, 2'b00, 0, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00);
        vecs[9]  = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, C_BR,   2'b00, 2'b00);
        vecs[10] = mk(4, 0, 0, 0, 4, 2'b10, 0, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00);
        vecs[11] = mk(4, 0, 0, 0, 4, 2'b01, 0, 0, 0, 0, 0, C_LW,   2'b00, 2'b00);
        vecs[12] = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 0, C_NONE, 2'b00, 2'b00);

        // Reset and post-reset flush.
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_ctl", 32'(ctl), 32'(C_INIT));
        chk("reset_memerr", 32'(MemErr), 32'd0);
        chk_counts("reset");
        rst = 1'b1;
        #1;
        chk("init1_ctl", 32'(ctl), 32'(C_INIT));
        tick(1, 1);
        #1;
        chk("init2_ctl", 32'(ctl), 32'(C_INIT));
        tick(1, 1);
        #1;
        chk("run_ctl", 32'(ctl), 32'(C_NONE));
        chk_counts("init");
        $display("init: flush sequence done, StallCount=%0d FlushCount=%0d", StallCount, FlushCount);

        // Table-driven forwarding and hazard decisions.
        for (int i = 0; i < 13; i++) begin
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
            RdE = vecs[i].rde; ResultSrcE = vecs[i].rsrc; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
            RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww; PCSrcE = vecs[i].pc;
            #1;
            chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].ctl));
            chk($sformatf("vec%0d_fwda", i), 32'(ForwardAE), 32'(vecs[i].fa));
            chk($sformatf("vec%0d_fwdb", i), 32'(ForwardBE), 32'(vecs[i].fb));
            $display("vec %0d: ctl=%b fa=%b fb=%b", i, ctl, ForwardAE, ForwardBE);
            tick(vecs[i].ctl[6], vecs[i].ctl[1]);
        end
        clear_inputs();
        #1;
        chk_counts("vectors");

        // Memory wait of 4 cycles with a load-use hazard and branch overridden by the freeze.
        MemReqM = 1; MemReadyM = 0;
        Rs2D = 3; RdE = 3; ResultSrcE = 2'b01; PCSrcE = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("memwait%0d_ctl", i), 32'(ctl), 32'(C_MEM));
            tick(1, 0);
        end
        MemReadyM = 1;
        #1;
        chk("memready_ctl", 32'(ctl), 32'(C_BR));
        tick(0, 1);
        clear_inputs();
        #1;
        chk("memdone_ctl", 32'(ctl), 32'(C_NONE));
        chk("memdone_memerr", 32'(MemErr), 32'd0);
        chk_counts("memwait");
        $display("memwait: 4-cycle freeze done, MemErr=%0d", MemErr);

        // Timeout: 15 frozen cycles, release on the 16th, sticky error afterwards.
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 15; i++) begin
            #1;
            chk($sformatf("timeout%0d_ctl", i), 32'(ctl), 32'(C_MEM));
            tick(1, 0);
        end
        #1;
        chk("timeout_release_ctl", 32'(ctl), 32'(C_NONE));
        chk("timeout_release_memerr", 32'(MemErr), 32'd0);
        tick(0, 0);
        MemReqM = 0;
        #1;
        chk("timeout_memerr", 32'(MemErr), 32'd1);
        tick(0, 0);
        #1;
        chk("timeout_memerr_sticky", 32'(MemErr), 32'd1);
        chk_counts("timeout");
        $display("timeout: released after 15 frozen cycles, MemErr=%0d", MemErr);

        // Saturation under a persistent load-use hazard.
        Rs1D = 4; RdE = 4; ResultSrcE = 2'b01;
        for (int i = 0; i < 70000; i++) tick(1, 1);
        #1;
        chk("sat_stallcount", 32'(StallCount), 32'hFFFF);
        chk("sat_flushcount", 32'(FlushCount), 32'hFFFF);
        chk_counts("sat");
        $display("saturation: StallCount=%0h FlushCount=%0h", StallCount, FlushCount);
        clear_inputs();

        // Reset asserted while in MEM_WAIT.
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("prereset%0d_ctl", i), 32'(ctl), 32'(C_MEM));
            tick(1, 0);
        end
        #2;
        rst = 1'b0;
        Rs1E = 5; RdM = 5; RegWriteM = 1;
        exp_sc = 0; exp_fc = 0;
        #1;
        chk("midreset_ctl", 32'(ctl), 32'(C_INIT));
        chk("midreset_memerr", 32'(MemErr), 32'd0);
        chk("midreset_fwda", 32'(ForwardAE), 32'(2'b10));
        chk_counts("midreset");
        @(negedge clk);
        chk_counts("held_reset");
        clear_inputs();
        rst = 1'b1;
        #1;
        tick(1, 1);
        tick(1, 1);
        #1;
        chk("rerun_ctl", 32'(ctl), 32'(C_NONE));
        chk("rerun_memerr", 32'(MemErr), 32'd0);
        chk_counts("rerun");
        $display("midreset: wait aborted, StallCount=%0d FlushCount=%0d", StallCount, FlushCount);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum memory-wait stall cycles before forced release.
REQ-002 Parameter INIT_CYCLES, default 2: post-reset pipeline flush length, in cycles.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 Rs1D, Rs2D  in  5 each  source registers of the instruction in Decode.
REQ-006 Rs1E, Rs2E, RdE  in  5 each  sources and destination of the instruction in Execute.
REQ-007 ResultSrcE  in  2  Execute result select; 2'b01 marks a load.
REQ-008 RdM, RdW  in  5 each  destinations in Memory and Writeback.
REQ-009 RegWriteM, RegWriteW  in  1 each  register-write enables in Memory and Writeback.
REQ-010 PCSrcE  in  1  branch or jump taken in Execute.
REQ-011 MemReqM, MemReadyM  in  1 each  data-memory request and ready in the Memory stage.
REQ-012 StallF, StallD, StallE, StallM  out  1 each  hold the stage register.
REQ-013 FlushD, FlushE, FlushW  out  1 each  load a bubble into the stage register.
REQ-014 ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 = register file, 01 = Writeback result, 10 = Memory ALU result.
REQ-015 MemErr  out  1  sticky memory-timeout flag.
REQ-016 StallCount, FlushCount  out  16 each  saturating performance counters.

Function
REQ-017 The FSM SHALL have three states: INIT, RUN and MEM_WAIT, with a wait counter waitCnt of width ceil(log2(TIMEOUT+1)).
REQ-018 ForwardAE SHALL be 10 if RegWriteM && RdM!=0 && RdM==Rs1E; otherwise 01 if RegWriteW && RdW!=0 && RdW==Rs1E; otherwise 00. ForwardBE follows the same rule using Rs2E.
REQ-019 Forwarding outputs SHALL be combinational and valid in every state.
REQ-020 lwStall = (ResultSrcE==01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
REQ-021 memStall = MemReqM && !MemReadyM && waitCnt<TIMEOUT, and is evaluated only in RUN or MEM_WAIT.
REQ-022 Outputs in INIT: StallF=1, FlushD=FlushE=FlushW=1, all other stall and flush outputs 0.
REQ-023 INIT SHALL last exactly INIT_CYCLES cycles after rst deasserts, then go to RUN with waitCnt=0.
REQ-024 When memStall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
REQ-025 memStall overrides lwStall and PCSrcE, which are re-evaluated once the freeze ends.
REQ-026 RUN with memStall: waitCnt<=1 and the next state is MEM_WAIT.
REQ-027 MEM_WAIT with MemReadyM=1: no stall that cycle, waitCnt<=0, next state RUN.
REQ-028 MEM_WAIT, not ready, waitCnt<TIMEOUT: stall, waitCnt<=waitCnt+1.
REQ-029 MEM_WAIT, not ready, waitCnt==TIMEOUT: no stall, MemErr<=1, waitCnt<=0, next state RUN; at most TIMEOUT consecutive frozen cycles occur.
REQ-030 RUN without memStall, PCSrcE=1: FlushD=FlushE=1, StallF=StallD=0; this holds even when lwStall=1 (branch wins).
REQ-031 RUN without memStall, lwStall=1, PCSrcE=0: StallF=StallD=1, FlushE=1, for one cycle per hazard occurrence.
REQ-032 In every other case, all stall and flush outputs SHALL be 0.
REQ-033 StallCount SHALL increment on every cycle where StallF=1, and FlushCount on every cycle where FlushE=1; both saturate at 16'hFFFF and never wrap.
REQ-034 MemErr SHALL be cleared only by reset.

Reset
REQ-035 While rst=0, the block SHALL asynchronously hold state=INIT, init counter=0, waitCnt=0, MemErr=0, StallCount=0 and FlushCount=0.
REQ-036 During reset the outputs SHALL match the INIT values in REQ-022, with ForwardAE/BE combinational.
REQ-037 Reset asserted in MEM_WAIT SHALL abort the wait immediately, with no MemErr.
REQ-038 Counters SHALL not count reset-asserted cycles; they do count INIT cycles after release.

Verification
REQ-039 Release rst -> StallF=FlushD=FlushE=FlushW=1 for exactly 2 cycles, then all 0; FlushCount=2, StallCount=2.
REQ-040 Forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. With RdM=0 -> ForwardAE=01. With RdM=RdW=0 -> 00.
REQ-041 Load-use: ResultSrcE=01, RdE=3, Rs2D=3 -> one cycle of StallF=StallD=FlushE=1; adding PCSrcE=1 the same cycle -> FlushD=FlushE=1, StallF=0.
REQ-042 Memory wait: MemReqM=1, MemReadyM=0 for 4 cycles, then 1 -> StallF/D/E/M and FlushW high for exactly 4 cycles; MemErr stays 0.
REQ-043 Timeout: MemReqM=1, MemReadyM held 0 with TIMEOUT=15 -> 15 frozen cycles, release on the 16th, MemErr=1 thereafter until rst.
REQ-044 Saturation and reset mid-wait: force 70000 load-use stalls -> StallCount=FFFF; assert rst during MEM_WAIT -> immediate INIT outputs, counters 0.
